// File: rtl/rtc_counter.sv
// Real-time clock: divides clk down to a 1 Hz tick and keeps 24h hour:minute:second
// with load, alarm and day-rollover pulses plus a 12h display view.
module rtc_counter #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned RST_HOUR = 0,
  parameter int unsigned RST_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [5:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic [5:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [3:0] hour12,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick,
  output logic       alarm_hit,
  output logic       load_err
);

  localparam int unsigned TW = 6;
  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  // Out-of-range reset parameters fall back to zero so the time is always legal
  localparam logic [TW-1:0] RST_H = TW'((RST_HOUR > 23) ? 0 : RST_HOUR);
  localparam logic [TW-1:0] RST_M = TW'((RST_MIN  > 59) ? 0 : RST_MIN);

  logic [PW-1:0] presc_q;

  logic          wrap_c;
  logic          load_ok_c;
  logic          sec_carry_c;
  logic          min_carry_c;
  logic          day_c;
  logic          alarm_match_c;
  logic [TW-1:0] sec_nxt_c;
  logic [TW-1:0] min_nxt_c;
  logic [TW-1:0] hour_nxt_c;

  assign wrap_c    = run && (presc_q == PRESC_MAX);
  assign load_ok_c = (load_hour <= TW'(23)) && (load_min <= TW'(59)) &&
                     (load_sec <= TW'(59));

  // Time after one second elapses; only committed on an unloaded wrap
  always_comb begin
    sec_carry_c = (second == TW'(59));
    min_carry_c = sec_carry_c && (minute == TW'(59));
    day_c       = min_carry_c && (hour == TW'(23));
    sec_nxt_c   = sec_carry_c ? '0 : second + TW'(1);
    min_nxt_c   = minute;
    hour_nxt_c  = hour;
    if (sec_carry_c) begin
      min_nxt_c = (minute == TW'(59)) ? '0 : minute + TW'(1);
    end
    if (min_carry_c) begin
      hour_nxt_c = (hour == TW'(23)) ? '0 : hour + TW'(1);
    end
  end

  // Alarm compares against the post-tick time, so loads can never trigger it
  assign alarm_match_c = alarm_en &&
                         (alarm_hour <= TW'(23)) && (alarm_min <= TW'(59)) &&
                         (hour_nxt_c == alarm_hour) && (min_nxt_c == alarm_min) &&
                         (sec_nxt_c == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      second    <= '0;
      minute    <= RST_M;
      hour      <= RST_H;
      sec_tick  <= 1'b0;
      day_tick  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      day_tick  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        // Any load suppresses the tick; an invalid one also freezes the prescaler
        if (load_ok_c) begin
          hour    <= load_hour;
          minute  <= load_min;
          second  <= load_sec;
          presc_q <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (run) begin
        if (wrap_c) begin
          presc_q   <= '0;
          second    <= sec_nxt_c;
          minute    <= min_nxt_c;
          hour      <= hour_nxt_c;
          sec_tick  <= 1'b1;
          day_tick  <= day_c;
          alarm_hit <= alarm_match_c;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

  // 12h display view of the registered hour
  always_comb begin
    pm = (hour >= TW'(12));
    if (hour == '0) begin
      hour12 = 4'd12;
    end else if (hour <= TW'(12)) begin
      hour12 = hour[3:0];
    end else begin
      hour12 = 4'(hour - TW'(12));
    end
  end

endmodule

// File: tb/tb_rtc_counter.sv
// Directed bench for rtc_counter at CLK_HZ=4 with non-zero reset hour/minute.
module tb_rtc_counter;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       load;
  logic [5:0] load_hour;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [5:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic [5:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [3:0] hour12;
  logic       pm;
  logic       sec_tick;
  logic       day_tick;
  logic       alarm_hit;
  logic       load_err;

  int total = 0;
  int bad   = 0;

  rtc_counter #(.CLK_HZ(4), .RST_HOUR(9), .RST_MIN(30)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
    .hour(hour), .minute(minute), .second(second),
    .hour12(hour12), .pm(pm),
    .sec_tick(sec_tick), .day_tick(day_tick),
    .alarm_hit(alarm_hit), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".hour"}, 32'(hour), 32'(h));
    chk({tag, ".min"},  32'(minute), 32'(m));
    chk({tag, ".sec"},  32'(second), 32'(s));
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load      = 1'b1;
    load_hour = 6'(h);
    load_min  = 6'(m);
    load_sec  = 6'(s);
    step();
    load      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; load = 1'b0;
    load_hour = '0; load_min = '0; load_sec = '0;
    alarm_hour = '0; alarm_min = '0; alarm_en = 1'b0;

    // Reset values
    #12;
    chk_time("rst", 9, 30, 0);
    chk("rst.sec_tick", 32'(sec_tick), 0);
    chk("rst.day_tick", 32'(day_tick), 0);
    chk("rst.alarm_hit", 32'(alarm_hit), 0);
    chk("rst.load_err", 32'(load_err), 0);
    chk("rst.hour12", 32'(hour12), 9);
    chk("rst.pm", 32'(pm), 0);

    // Tick every 4 cycles, first on cycle 4
    rst_n = 1'b1;
    run   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("run.sec_tick", 32'(sec_tick), 32'((i % 4) == 0));
      chk("run.sec", 32'(second), 32'(i / 4));
    end

    // Day rollover
    do_load(23, 59, 58);
    chk_time("ld235958", 23, 59, 58);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("roll.sec_tick", 32'(sec_tick), 32'((i % 4) == 0));
      chk("roll.day_tick", 32'(day_tick), 32'(i == 8));
      if (i == 4) begin
        chk_time("roll.t1", 23, 59, 59);
        chk("roll.pm1", 32'(pm), 1);
        chk("roll.h12_1", 32'(hour12), 11);
      end
    end
    chk_time("roll.t2", 0, 0, 0);
    chk("roll.pm2", 32'(pm), 0);
    chk("roll.h12_2", 32'(hour12), 12);

    // Invalid load leaves time alone and flags load_err for one cycle
    do_load(25, 0, 0);
    chk("bad25.load_err", 32'(load_err), 1);
    chk_time("bad25", 0, 0, 0);
    step();
    chk("bad25.err_clr", 32'(load_err), 0);
    do_load(12, 30, 0);
    chk_time("ld1230", 12, 30, 0);
    chk("ld1230.h12", 32'(hour12), 12);
    chk("ld1230.pm", 32'(pm), 1);
    chk("ld1230.load_err", 32'(load_err), 0);

    // Invalid load mid-second freezes the prescaler for that cycle
    step();
    step();
    chk("pre.tick", 32'(sec_tick), 0);
    do_load(12, 60, 0);
    chk("bad60.load_err", 32'(load_err), 1);
    chk("bad60.tick", 32'(sec_tick), 0);
    step();
    chk("bad60.tick2", 32'(sec_tick), 0);
    step();
    chk("bad60.tick3", 32'(sec_tick), 1);
    chk_time("bad60", 12, 30, 1);

    // Alarm fires on tick into 07:00:00
    alarm_en = 1'b1; alarm_hour = 6'd7; alarm_min = 6'd0;
    do_load(6, 59, 59);
    chk("al.ld_hit", 32'(alarm_hit), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("al.hit", 32'(alarm_hit), 32'(i == 4));
    end
    chk_time("al", 7, 0, 0);
    chk("al.h12", 32'(hour12), 7);

    // Loading the alarm time itself must not fire
    do_load(7, 0, 0);
    chk("al2.ld_hit", 32'(alarm_hit), 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("al2.hit", 32'(alarm_hit), 0);
    end
    chk_time("al2", 7, 0, 1);
    alarm_en = 1'b0;

    // Load on the wrap cycle wins: no increment, no tick
    step();
    step();
    step();
    do_load(10, 20, 30);
    chk_time("ldwrap", 10, 20, 30);
    chk("ldwrap.tick", 32'(sec_tick), 0);
    chk("ldwrap.day", 32'(day_tick), 0);

    // Freeze with run=0, resume from held prescaler
    step();
    step();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz.tick", 32'(sec_tick), 0);
    end
    chk_time("frz", 10, 20, 30);
    run = 1'b1;
    step();
    chk("res.tick1", 32'(sec_tick), 0);
    step();
    chk("res.tick2", 32'(sec_tick), 1);
    chk_time("res", 10, 20, 31);

    // Asynchronous reset between edges while sec_tick is high
    #2;
    rst_n = 1'b0;
    #1;
    chk_time("arst", 9, 30, 0);
    chk("arst.tick", 32'(sec_tick), 0);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("post.tick", 32'(sec_tick), 32'(i == 4));
    end
    chk_time("post", 9, 30, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
